// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, request type and arbiter states for rf writeback scheduling
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// rtl/rf_rr_arb2.sv - two-way round-robin arbiter for the register-file write port
module rf_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  import rf_pkg::*;

  arb_state_t r_last;
  arb_state_t w_last_nxt;

  // Reset to LAST1 so ch0 wins the first contended cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= LAST1;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  always_comb begin
    o_gnt      = 2'b00;
    w_last_nxt = r_last;
    case (i_req)
      2'b01: begin
        o_gnt      = 2'b01;
        w_last_nxt = LAST0;
      end
      2'b10: begin
        o_gnt      = 2'b10;
        w_last_nxt = LAST1;
      end
      2'b11: begin
        if (r_last == LAST1) begin
          o_gnt      = 2'b01;
          w_last_nxt = LAST0;
        end else begin
          o_gnt      = 2'b10;
          w_last_nxt = LAST1;
        end
      end
      default: begin
        o_gnt      = 2'b00;
        w_last_nxt = r_last;
      end
    endcase
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - shares the RF write port between ALU and load writeback,
// and tracks pending writes per register for RAW/WAW hazard detection
module rf_wb_scheduler #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int NREGS  = rf_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ready,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic [ADDR_W-1:0] q2_addr,
  output logic              q1_busy,
  output logic              q2_busy,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              rf_we3
);
  import rf_pkg::*;

  wb_req_t           w_req0;
  wb_req_t           w_req1;
  wb_req_t           w_sel;
  logic [1:0]        w_gnt;
  logic              w_fire;
  logic              w_rsv_fire;
  logic [NREGS-1:0]  r_busy;
  logic [NREGS-1:0]  w_busy_nxt;
  logic [ADDR_W-1:0] r_a3;
  logic [DATA_W-1:0] r_wd3;
  logic              r_we3;

  assign w_req0 = '{valid: wb0_valid, addr: wb0_addr, data: wb0_data};
  assign w_req1 = '{valid: wb1_valid, addr: wb1_addr, data: wb1_data};

  rf_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({w_req1.valid, w_req0.valid}),
    .o_gnt (w_gnt)
  );

  assign wb0_ready = w_gnt[0];
  assign wb1_ready = w_gnt[1];
  // A grant is only ever issued to a valid channel, so any grant is a handshake.
  assign w_fire    = |w_gnt;
  assign w_sel     = w_gnt[1] ? w_req1 : w_req0;

  // A writeback retiring this cycle already frees its register for new readers/producers.
  assign rsv_ready  = !r_busy[rsv_addr] || (rsv_addr == REG_ZERO) ||
                      (w_fire && (w_sel.addr == rsv_addr));
  assign w_rsv_fire = rsv_valid && rsv_ready;

  assign q1_busy = r_busy[q1_addr] && (q1_addr != REG_ZERO) &&
                   !(w_fire && (w_sel.addr == q1_addr));
  assign q2_busy = r_busy[q2_addr] && (q2_addr != REG_ZERO) &&
                   !(w_fire && (w_sel.addr == q2_addr));

  // Set is applied after clear so a new producer supersedes a retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_fire) begin
      w_busy_nxt[w_sel.addr] = 1'b0;
    end
    if (w_rsv_fire && (rsv_addr != REG_ZERO)) begin
      w_busy_nxt[rsv_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we3 <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else if (w_fire) begin
      r_we3 <= (w_sel.addr != REG_ZERO);
      r_a3  <= (w_sel.addr != REG_ZERO) ? w_sel.addr : REG_ZERO;
      r_wd3 <= w_sel.data;
    end else begin
      r_we3 <= 1'b0;
    end
  end

  assign rf_a3  = r_a3;
  assign rf_wd3 = r_wd3;
  assign rf_we3 = r_we3;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - directed table-driven bench for rf_wb_scheduler
module tb_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic [4:0]  q1_addr;
  logic [4:0]  q2_addr;
  logic        q1_busy;
  logic        q2_busy;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_we3;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        rv;
    logic [4:0]  ra;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_r0;
    logic        e_r1;
    logic        e_rr;
    logic        e_q1;
    logic        e_q2;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  rf_wb_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .wb0_valid (wb0_valid),
    .wb0_addr  (wb0_addr),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_addr  (wb1_addr),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .q1_addr   (q1_addr),
    .q2_addr   (q2_addr),
    .q1_busy   (q1_busy),
    .q2_busy   (q2_busy),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .rf_we3    (rf_we3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    wb0_valid = v.v0; wb0_addr = v.a0; wb0_data = v.d0;
    wb1_valid = v.v1; wb1_addr = v.a1; wb1_data = v.d1;
    rsv_valid = v.rv; rsv_addr = v.ra;
    q1_addr   = v.q1; q2_addr  = v.q2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //           v0 a0  d0   v1 a1  d1  rv ra  q1  q2   r0 r1 rr q1 q2  we a3  wd
    vecs.push_back('{0, 0, 0,   0, 0, 0,  0, 0, 5,  0,   0, 0, 1, 0, 0,  0, 5, 11});
    vecs.push_back('{1, 5, 56,  0, 0, 0,  0, 0, 5,  0,   1, 0, 1, 0, 0,  1, 5, 56});
    vecs.push_back('{0, 0, 0,   1, 9, 77, 0, 0, 5,  0,   0, 1, 1, 0, 0,  1, 9, 77});
    vecs.push_back('{1, 4, 26,  1, 7, 99, 0, 0, 4,  7,   1, 0, 1, 0, 0,  1, 4, 26});
    vecs.push_back('{1, 4, 26,  1, 7, 99, 0, 0, 4,  7,   0, 1, 1, 0, 0,  1, 7, 99});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  1, 3, 3,  3,   0, 0, 1, 0, 0,  0, 7, 99});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  1, 3, 3,  3,   0, 0, 0, 1, 1,  0, 7, 99});
    vecs.push_back('{0, 0, 0,   1, 3, 33, 0, 3, 3,  3,   0, 1, 1, 0, 0,  1, 3, 33});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  0, 3, 3,  3,   0, 0, 1, 0, 0,  0, 3, 33});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  1, 3, 3,  3,   0, 0, 1, 0, 0,  0, 3, 33});
    vecs.push_back('{1, 3, 44,  0, 0, 0,  1, 3, 3,  3,   1, 0, 1, 0, 0,  1, 3, 44});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  0, 3, 3,  3,   0, 0, 0, 1, 1,  0, 3, 44});
    vecs.push_back('{0, 0, 0,   1, 3, 55, 0, 3, 3,  3,   0, 1, 1, 0, 0,  1, 3, 55});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  0, 3, 3,  0,   0, 0, 1, 0, 0,  0, 3, 55});
    vecs.push_back('{1, 0, 123, 0, 0, 0,  0, 0, 0,  0,   1, 0, 1, 0, 0,  0, 0, 123});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  1, 0, 0,  0,   0, 0, 1, 0, 0,  0, 0, 123});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  0, 0, 0,  0,   0, 0, 1, 0, 0,  0, 0, 123});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  1, 10, 10, 10, 0, 0, 1, 0, 0,  0, 0, 123});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  0, 10, 3, 10,  0, 0, 0, 0, 1,  0, 0, 123});
    vecs.push_back('{1, 11, 1,  1, 10, 2, 0, 10, 10, 10, 0, 1, 1, 0, 0,  1, 10, 2});
    vecs.push_back('{0, 0, 0,   0, 0, 0,  0, 10, 10, 10, 0, 0, 1, 0, 0,  0, 10, 2});

    rst = 1'b0;
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'd11;
    wb1_valid = 1'b0; wb1_addr = 5'd0; wb1_data = 32'd0;
    rsv_valid = 1'b0; rsv_addr = 5'd0;
    q1_addr = 5'd5; q2_addr = 5'd0;
    #60;
    chk("rst_we3", {31'd0, rf_we3}, 32'd0);
    chk("rst_a3", {27'd0, rf_a3}, 32'd0);
    chk("rst_wd3", rf_wd3, 32'd0);
    chk("rst_q1_busy", {31'd0, q1_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_we3", {31'd0, rf_we3}, 32'd1);
    chk("rel_a3", {27'd0, rf_a3}, 32'd5);
    chk("rel_wd3", rf_wd3, 32'd11);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_wb0_ready", i), {31'd0, wb0_ready}, {31'd0, vecs[i].e_r0});
      chk($sformatf("v%0d_wb1_ready", i), {31'd0, wb1_ready}, {31'd0, vecs[i].e_r1});
      chk($sformatf("v%0d_rsv_ready", i), {31'd0, rsv_ready}, {31'd0, vecs[i].e_rr});
      chk($sformatf("v%0d_q1_busy", i), {31'd0, q1_busy}, {31'd0, vecs[i].e_q1});
      chk($sformatf("v%0d_q2_busy", i), {31'd0, q2_busy}, {31'd0, vecs[i].e_q2});
      @(posedge clk); #1;
      chk($sformatf("v%0d_we3", i), {31'd0, rf_we3}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_a3", i), {27'd0, rf_a3}, {27'd0, vecs[i].e_a3});
      chk($sformatf("v%0d_wd3", i), rf_wd3, vecs[i].e_wd);
    end

    // Mid-operation reset: a write and a reservation in flight must vanish.
    @(negedge clk);
    wb0_valid = 1'b1; wb0_addr = 5'd6; wb0_data = 32'd66;
    wb1_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd12;
    q1_addr = 5'd12; q2_addr = 5'd0;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    chk("mid_we3_pre", {31'd0, rf_we3}, 32'd1);
    chk("mid_q1_busy_pre", {31'd0, q1_busy}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_we3", {31'd0, rf_we3}, 32'd0);
    chk("mid_a3", {27'd0, rf_a3}, 32'd0);
    chk("mid_wd3", rf_wd3, 32'd0);
    chk("mid_q1_busy", {31'd0, q1_busy}, 32'd0);
    @(posedge clk); #1;
    chk("mid_we3_held", {31'd0, rf_we3}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wb0_valid = 1'b1; wb0_addr = 5'd1; wb0_data = 32'd5;
    wb1_valid = 1'b1; wb1_addr = 5'd2; wb1_data = 32'd6;
    #1;
    chk("post_rst_wb0_ready", {31'd0, wb0_ready}, 32'd1);
    chk("post_rst_wb1_ready", {31'd0, wb1_ready}, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_a3", {27'd0, rf_a3}, 32'd1);
    chk("post_rst_wd3", rf_wd3, 32'd5);
    @(negedge clk);
    wb0_valid = 1'b0; wb1_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
